// File: rtl/pattern_seq_fsm.sv
// -----------------------------------------------------------------------------
// pattern_seq_fsm
//   Sequencer that walks IDLE -> S1 -> S2 -> {S3 | S4 -> S2 ...} and drives a
//   fixed bit pattern per state. S1 and S2 each last dwell+1 cycles. The dwell
//   value is captured when the state is entered. S4 is a one-cycle loop-back
//   state that counts its visits. S3 is terminal until clear.
//
//   Optional feature macro: PATTERN_SEQ_LOOP_LIMIT_EN
//     defined   : the S4 visit that brings loop_cnt to MAX_LOOPS exits to S3
//     undefined : S4 always returns to S2; loop_cnt saturates at MAX_LOOPS
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous reset, active low
//   start        in   launch a sequence from IDLE
//   A            in   branch select, sampled on the last S2 cycle
//   clear        in   synchronous abort to IDLE (highest priority)
//   dwell        in   [DWELL_W]  S1/S2 length minus one
//   pattern_out  out  [OUT_W]    registered pattern for the current state
//   state_out    out  [3]        IDLE=0 S1=1 S2=2 S3=3 S4=4
//   done         out             high while in S3
//   loop_cnt     out  [clog2(MAX_LOOPS+1)]  S4 entries since leaving IDLE
// -----------------------------------------------------------------------------
module pattern_seq_fsm #(
    parameter int OUT_W     = 3,
    parameter int DWELL_W   = 4,
    parameter int MAX_LOOPS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             A,
    input  logic                             clear,
    input  logic [DWELL_W-1:0]               dwell,
    output logic [OUT_W-1:0]                 pattern_out,
    output logic [2:0]                       state_out,
    output logic                             done,
    output logic [$clog2(MAX_LOOPS+1)-1:0]   loop_cnt
);

    localparam int LW = $clog2(MAX_LOOPS + 1);
    localparam logic [LW-1:0] LOOP_MAX = LW'(MAX_LOOPS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4
    } state_t;

    // Alternating pattern with ones on even bit positions.
    function automatic logic [OUT_W-1:0] alt_pat();
        logic [OUT_W-1:0] p;
        for (int i = 0; i < OUT_W; i++) p[i] = (i % 2 == 0);
        return p;
    endfunction

    localparam logic [OUT_W-1:0] PAT_S1 = alt_pat();
    localparam logic [OUT_W-1:0] PAT_S2 = ~PAT_S1;
    localparam logic [OUT_W-1:0] PAT_S3 = '1;
    localparam logic [OUT_W-1:0] PAT_S4 = {{(OUT_W-1){1'b1}}, 1'b0};

    function automatic logic [OUT_W-1:0] pat_of(state_t s);
        case (s)
            ST_S1:   return PAT_S1;
            ST_S2:   return PAT_S2;
            ST_S3:   return PAT_S3;
            ST_S4:   return PAT_S4;
            default: return '0;
        endcase
    endfunction

    state_t              r_state;
    logic [OUT_W-1:0]    r_pattern;
    logic                r_done;
    logic [LW-1:0]       r_loop_cnt;
    logic [DWELL_W-1:0]  r_cnt;

    state_t w_nxt;
    logic   w_dwell_st;   // next state is a dwell state (S1/S2)
    logic   w_load;       // entering a dwell state: capture dwell
    logic   w_s4_entry;

    always_comb begin
        w_nxt = ST_IDLE;
        if (clear) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_nxt = start ? ST_S1 : ST_IDLE;
                ST_S1:   w_nxt = (r_cnt == '0) ? ST_S2 : ST_S1;
                ST_S2:   w_nxt = (r_cnt == '0) ? (A ? ST_S4 : ST_S3) : ST_S2;
                ST_S3:   w_nxt = ST_S3;
`ifdef PATTERN_SEQ_LOOP_LIMIT_EN
                // loop_cnt already counts this visit, so compare directly.
                ST_S4:   w_nxt = (r_loop_cnt == LOOP_MAX) ? ST_S3 : ST_S2;
`else
                ST_S4:   w_nxt = ST_S2;
`endif
                default: w_nxt = ST_IDLE;  // illegal encodings recover
            endcase
        end
    end

    assign w_dwell_st = (w_nxt == ST_S1) || (w_nxt == ST_S2);
    // S2 staying in S2 is a countdown; any other arrival into S1/S2 reloads.
    assign w_load     = w_dwell_st && (w_nxt != r_state);
    assign w_s4_entry = (w_nxt == ST_S4) && (r_state != ST_S4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pattern  <= '0;
            r_done     <= 1'b0;
            r_loop_cnt <= '0;
            r_cnt      <= '0;
        end else begin
            r_state   <= w_nxt;
            r_pattern <= pat_of(w_nxt);
            r_done    <= (w_nxt == ST_S3);

            if (w_load)
                r_cnt <= dwell;
            else if (w_dwell_st && r_cnt != '0)
                r_cnt <= r_cnt - DWELL_W'(1);
            else
                r_cnt <= '0;

            if (w_nxt == ST_IDLE)
                r_loop_cnt <= '0;
            else if (w_s4_entry && r_loop_cnt != LOOP_MAX)
                r_loop_cnt <= r_loop_cnt + LW'(1);
        end
    end

    assign pattern_out = r_pattern;
    assign state_out   = r_state;
    assign done        = r_done;
    assign loop_cnt    = r_loop_cnt;

endmodule

// File: tb/tb_pattern_seq_fsm.sv
// -----------------------------------------------------------------------------
// tb_pattern_seq_fsm
//   Self-checking bench for pattern_seq_fsm with OUT_W=3, DWELL_W=4,
//   MAX_LOOPS=2. Table vectors, hand-written corner sequences, and a
//   randomized run against a cycle-age reference model. Honors
//   PATTERN_SEQ_LOOP_LIMIT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pattern_seq_fsm;

    localparam int OUT_W     = 3;
    localparam int DWELL_W   = 4;
    localparam int MAX_LOOPS = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                start, A, clear;
    logic [DWELL_W-1:0]  dwell;
    logic [OUT_W-1:0]    pattern_out;
    logic [2:0]          state_out;
    logic                done;
    logic [1:0]          loop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pattern_seq_fsm #(.OUT_W(OUT_W), .DWELL_W(DWELL_W), .MAX_LOOPS(MAX_LOOPS)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .clear(clear),
        .dwell(dwell), .pattern_out(pattern_out), .state_out(state_out),
        .done(done), .loop_cnt(loop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks how many cycles have been spent in the current state and the
    // dwell captured on entry; a dwell state ends when age reaches it.
    int m_state, m_age, m_len, m_loops;

    task automatic model_reset();
        m_state = 0; m_age = 0; m_len = 0; m_loops = 0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic c, input int d);
        if (c) begin
            m_state = 0; m_loops = 0;
        end else begin
            case (m_state)
                0: if (s) begin m_state = 1; m_len = d; m_age = 0; end
                1: if (m_age == m_len) begin m_state = 2; m_len = d; m_age = 0; end
                   else m_age++;
                2: if (m_age == m_len) begin
                       if (a) begin
                           m_state = 4;
                           if (m_loops < MAX_LOOPS) m_loops++;
                       end else m_state = 3;
                   end else m_age++;
                4: begin
`ifdef PATTERN_SEQ_LOOP_LIMIT_EN
                       if (m_loops == MAX_LOOPS) m_state = 3;
                       else begin m_state = 2; m_len = d; m_age = 0; end
`else
                       m_state = 2; m_len = d; m_age = 0;
`endif
                   end
                default: m_state = 3;
            endcase
        end
    endtask

    function automatic logic [2:0] pat_for(int st);
        case (st)
            1: return 3'b101;
            2: return 3'b010;
            3: return 3'b111;
            4: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"},   32'(state_out),   32'(m_state));
        chk({tag, ".pattern"}, 32'(pattern_out), 32'(pat_for(m_state)));
        chk({tag, ".done"},    32'(done),        32'(m_state == 3));
        chk({tag, ".loop"},    32'(loop_cnt),    32'(m_loops));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input logic s, input logic a, input logic c, input logic [3:0] d);
        start = s; A = a; clear = c; dwell = d;
        @(posedge clk);
        model_step(s, a, c, int'(d));
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       st, a, clr;
        logic [3:0] dw;
        logic [2:0] e_state, e_pat;
        logic       e_done;
        logic [1:0] e_loop;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic st, logic a, logic clr, logic [3:0] dw,
                                logic [2:0] es, logic [2:0] ep, logic ed, logic [1:0] el);
        vec_t v;
        v.st = st; v.a = a; v.clr = clr; v.dw = dw;
        v.e_state = es; v.e_pat = ep; v.e_done = ed; v.e_loop = el;
        return v;
    endfunction

    initial begin
        // A=0 path: S1, S2, then S3 held until clear.
        vq.push_back(mk(1, 0, 0, 0, 3'd1, 3'b101, 0, 2'd0));
        vq.push_back(mk(0, 0, 0, 0, 3'd2, 3'b010, 0, 2'd0));
        vq.push_back(mk(0, 0, 0, 0, 3'd3, 3'b111, 1, 2'd0));
        vq.push_back(mk(0, 0, 0, 0, 3'd3, 3'b111, 1, 2'd0));
        vq.push_back(mk(0, 0, 1, 0, 3'd0, 3'b000, 0, 2'd0));
        // start together with clear keeps IDLE.
        vq.push_back(mk(1, 0, 1, 0, 3'd0, 3'b000, 0, 2'd0));
        vq.push_back(mk(1, 1, 1, 0, 3'd0, 3'b000, 0, 2'd0));
        // A=1 held: loop through S4.
        vq.push_back(mk(1, 1, 0, 0, 3'd1, 3'b101, 0, 2'd0));
        vq.push_back(mk(0, 1, 0, 0, 3'd2, 3'b010, 0, 2'd0));
        vq.push_back(mk(0, 1, 0, 0, 3'd4, 3'b110, 0, 2'd1));
        vq.push_back(mk(0, 1, 0, 0, 3'd2, 3'b010, 0, 2'd1));
        vq.push_back(mk(0, 1, 0, 0, 3'd4, 3'b110, 0, 2'd2));
`ifdef PATTERN_SEQ_LOOP_LIMIT_EN
        vq.push_back(mk(0, 1, 0, 0, 3'd3, 3'b111, 1, 2'd2));
        vq.push_back(mk(0, 1, 0, 0, 3'd3, 3'b111, 1, 2'd2));
`else
        vq.push_back(mk(0, 1, 0, 0, 3'd2, 3'b010, 0, 2'd2));
        vq.push_back(mk(0, 1, 0, 0, 3'd4, 3'b110, 0, 2'd2));
`endif
        vq.push_back(mk(0, 1, 1, 0, 3'd0, 3'b000, 0, 2'd0));
        // clear during S2.
        vq.push_back(mk(1, 1, 0, 0, 3'd1, 3'b101, 0, 2'd0));
        vq.push_back(mk(0, 1, 0, 0, 3'd2, 3'b010, 0, 2'd0));
        vq.push_back(mk(0, 1, 1, 0, 3'd0, 3'b000, 0, 2'd0));

        // ---------------- reset state ----------------
        reset = 1'b0; start = 0; A = 0; clear = 0; dwell = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_model("reset");
        reset = 1'b1;

        // ---------------- table phase ----------------
        foreach (vq[i]) begin
            apply(vq[i].st, vq[i].a, vq[i].clr, vq[i].dw);
            chk($sformatf("vec%0d.state", i),   32'(state_out),   32'(vq[i].e_state));
            chk($sformatf("vec%0d.pattern", i), 32'(pattern_out), 32'(vq[i].e_pat));
            chk($sformatf("vec%0d.done", i),    32'(done),        32'(vq[i].e_done));
            chk($sformatf("vec%0d.loop", i),    32'(loop_cnt),    32'(vq[i].e_loop));
        end

        // ---------------- dwell captured on entry ----------------
        // dwell=3 for the first two S1 cycles, then 0: S1 still runs 4
        // cycles and S2 (entered with dwell=0) runs one.
        begin
            logic [2:0] exp_st [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
            logic [3:0] dw_seq [6] = '{4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
            for (int i = 0; i < 6; i++) begin
                apply(i == 0, 1'b0, 1'b0, dw_seq[i]);
                chk($sformatf("dwell.c%0d", i), 32'(state_out), 32'(exp_st[i]));
            end
        end
        apply(0, 0, 1, 0);
        chk_model("dwell.clear");

        // ---------------- A=1 held for 12 cycles ----------------
        apply(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            apply(0, 1, 0, 0);
            chk_model($sformatf("loop12.c%0d", i));
`ifndef PATTERN_SEQ_LOOP_LIMIT_EN
            chk($sformatf("loop12.noS3.c%0d", i), 32'(state_out == 3'd3), 32'(0));
`endif
        end
`ifndef PATTERN_SEQ_LOOP_LIMIT_EN
        chk("loop12.sat", 32'(loop_cnt), 32'(MAX_LOOPS));
`endif
        apply(0, 0, 1, 0);

        // ---------------- async reset while in S4 ----------------
        apply(1, 1, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 1, 0, 0);
        chk("s4.before", 32'(state_out), 32'(4));
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_model("async_rst");
        @(negedge clk);
        reset = 1'b1;
        apply(0, 1, 0, 0);
        chk_model("post_rst.idle");
        apply(1, 1, 0, 0);
        chk_model("post_rst.start");
        apply(0, 0, 1, 0);

        // ---------------- randomized run ----------------
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 3) == 0, $urandom % 2, ($urandom % 16) == 0, 4'($urandom % 4));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
